fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the 64-bit-addressed, byte-array instruction memory.
- Owns the PC register and drives Inst_Address into the memory.
- Captures the 32-bit little-endian word the memory returns combinationally into an IF/ID pipeline register for the decoder.
- Handles stall, branch redirect with flush, out-of-range/misaligned faults and end-of-program halt.

---
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID capture, branch redirect/flush and fault/halt handling.
// Optional end-of-program halt on an all-zero word is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned MEM_BYTES = 116
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic [63:0] IFID_PC,
  output logic [31:0] IFID_Instruction,
  output logic        IFID_Valid,
  output logic        Fault,
  output logic        Halted
);

  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 4);
  localparam logic [31:0] NOP     = 32'h0000_0013;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_e;
`else
  typedef enum logic [1:0] {S_RUN, S_FAULT} state_e;
`endif

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_ins_q, ifid_ins_d;
  logic        valid_q, valid_d;

  // 65-bit sum so a wrapping PC+4 still compares as out of range
  logic [64:0] pc_plus4;
  logic        seq_oob;
  logic        tgt_bad;

  assign pc_plus4 = {1'b0, pc_q} + 65'd4;
  assign seq_oob  = pc_plus4 > {1'b0, LAST_PC};
  assign tgt_bad  = (Branch_Target[1:0] != 2'b00) || (Branch_Target > LAST_PC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      ifid_pc_q  <= '0;
      ifid_ins_q <= NOP;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_ins_q <= ifid_ins_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_pc_d  = ifid_pc_q;
    ifid_ins_d = ifid_ins_q;
    valid_d    = valid_q;
    case (state_q)
      S_RUN: begin
        if (Branch_Taken) begin
          valid_d = 1'b0;
          if (tgt_bad) begin
            state_d = S_FAULT;
          end else begin
            pc_d = Branch_Target;
          end
        end else if (!Stall) begin
`ifdef FETCH_HALT_EN
          if (Instruction == '0) begin
            state_d = S_HALT;
            valid_d = 1'b0;
          end else
`endif
          begin
            ifid_pc_d  = pc_q;
            ifid_ins_d = Instruction;
            valid_d    = 1'b1;
            // last legal word stays latched; PC parks on it
            if (seq_oob) begin
              state_d = S_FAULT;
            end else begin
              pc_d = pc_plus4[63:0];
            end
          end
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  assign Inst_Address     = pc_q;
  assign IFID_PC          = ifid_pc_q;
  assign IFID_Instruction = ifid_ins_q;
  assign IFID_Valid       = valid_q;
  assign Fault            = (state_q == S_FAULT);
`ifdef FETCH_HALT_EN
  assign Halted           = (state_q == S_HALT);
`else
  assign Halted           = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stall/branch traffic
// compared against a spec-level reference model over a byte-array instruction memory.
module tb_fetch_unit;

  localparam int unsigned MEM_BYTES = 116;
  localparam logic [63:0] LAST      = 64'(MEM_BYTES - 4);

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        Stall = 1'b0;
  logic        Branch_Taken = 1'b0;
  logic [63:0] Branch_Target = '0;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic [63:0] IFID_PC;
  logic [31:0] IFID_Instruction;
  logic        IFID_Valid;
  logic        Fault;
  logic        Halted;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(64'd0), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset_n(reset_n), .Stall(Stall), .Branch_Taken(Branch_Taken),
    .Branch_Target(Branch_Target), .Inst_Address(Inst_Address), .Instruction(Instruction),
    .IFID_PC(IFID_PC), .IFID_Instruction(IFID_Instruction), .IFID_Valid(IFID_Valid),
    .Fault(Fault), .Halted(Halted)
  );

  logic [7:0] mem [0:MEM_BYTES-1];

  function automatic logic [31:0] word_at(input logic [63:0] a);
    int unsigned i;
    if (a > LAST || a[1:0] != 2'b00) return 32'h0000_0013;
    i = int'(a[6:0]);
    return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
  endfunction

  always_comb Instruction = word_at(Inst_Address);

  function automatic void set_word(input int unsigned idx, input logic [31:0] w);
    mem[idx*4]   = w[7:0];
    mem[idx*4+1] = w[15:8];
    mem[idx*4+2] = w[23:16];
    mem[idx*4+3] = w[31:24];
  endfunction

  // reference model: 0 = running, 1 = halted, 2 = faulted
  int          m_mode;
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_ifins;
  logic        m_valid;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 64'd0; m_ifpc = '0; m_ifins = 32'h0000_0013; m_valid = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] w;
    if (m_mode != 0) begin
      m_valid = 1'b0;
    end else if (Branch_Taken) begin
      m_valid = 1'b0;
      if (Branch_Target % 4 != 0 || Branch_Target > LAST) m_mode = 2;
      else m_pc = Branch_Target;
    end else if (!Stall) begin
      w = word_at(m_pc);
      if (HALT_EN && w == 32'd0) begin
        m_mode = 1; m_valid = 1'b0;
      end else begin
        m_ifpc = m_pc; m_ifins = w; m_valid = 1'b1;
        if (m_pc + 4 > LAST) m_mode = 2;
        else m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  Inst_Address, m_pc);
    check({tag, ".ifpc"},  IFID_PC, m_ifpc);
    check({tag, ".ifins"}, 64'(IFID_Instruction), 64'(m_ifins));
    check({tag, ".valid"}, 64'(IFID_Valid), 64'(m_valid));
    check({tag, ".fault"}, 64'(Fault), 64'(m_mode == 2));
    check({tag, ".halt"},  64'(Halted), 64'(m_mode == 1));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  // reset pulsed mid-cycle; values must appear before any clock edge
  task automatic do_reset();
    @(posedge clk);
    #2 Branch_Taken = 1'b1; Branch_Target = 64'd8; Stall = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    Branch_Taken = 1'b0; Stall = 1'b0;
  endtask

  task automatic fill_mem(input int unsigned zero_pct);
    for (int unsigned i = 0; i < MEM_BYTES / 4; i++) begin
      if ($urandom_range(99) < zero_pct) set_word(i, 32'd0);
      else set_word(i, $urandom | 32'h1);
    end
  endtask

  initial begin
    fill_mem(0);
    set_word(0, 32'h0030_0593);
    do_reset();

    step("seq0");
    check("first_word", 64'(IFID_Instruction), 64'h0030_0593);
    check("first_addr", Inst_Address, 64'd4);
    step("seq1");
    Stall = 1'b1;
    repeat (3) step("stall");
    check("stall_addr", Inst_Address, 64'd8);
    Stall = 1'b0;
    step("unstall");
    check("unstall_ifpc", IFID_PC, 64'd8);
    for (int i = 0; i < 20 && m_pc != 64'd44; i++) step("to44");

    Branch_Taken = 1'b1; Branch_Target = 64'd88; Stall = 1'b1;
    step("branch");
    check("branch_addr", Inst_Address, 64'd88);
    Branch_Taken = 1'b0; Stall = 1'b0;
    step("after_branch");
    check("after_branch_ifpc", IFID_PC, 64'd88);

    Branch_Taken = 1'b1; Branch_Target = 64'd46;
    step("misalign");
    check("misalign_fault", 64'(Fault), 64'd1);
    Branch_Target = 64'd0;
    repeat (3) step("ignored");
    check("frozen_addr", Inst_Address, 64'd92);
    Branch_Taken = 1'b0;

    do_reset();
    repeat (35) step("eom");
    check("eom_fault", 64'(Fault), 64'd1);
    check("eom_pc", Inst_Address, 64'd112);

    set_word(28, 32'd0);
    do_reset();
    repeat (35) step("zero");
`ifdef FETCH_HALT_EN
    check("zero_halted", 64'(Halted), 64'd1);
    check("zero_ifpc", IFID_PC, 64'd108);
    check("zero_fault", 64'(Fault), 64'd0);
`else
    check("zero_ifpc", IFID_PC, 64'd112);
    check("zero_fault", 64'(Fault), 64'd1);
    check("zero_ins", 64'(IFID_Instruction), 64'd0);
`endif

    for (int ep = 0; ep < 8; ep++) begin
      fill_mem(6);
      do_reset();
      for (int c = 0; c < 150; c++) begin
        int unsigned r;
        Stall = ($urandom_range(3) == 0);
        Branch_Taken = ($urandom_range(9) == 0);
        r = $urandom_range(15);
        if (r == 0)      Branch_Target = {$urandom, $urandom};
        else if (r == 1) Branch_Target = 64'($urandom_range(111) | 1);
        else             Branch_Target = 64'($urandom_range(28) * 4);
        step("rand");
      end
      Stall = 1'b0; Branch_Taken = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
